// File: rtl/tdm_demux_pkg.sv
// Shared definitions for the TDM link: the receiver FSM state encoding
// and the default frame geometry. The transmitter is expected to import
// the same package.
package tdm_demux_pkg;

    localparam int NUM_CH_DEF = 4;
    localparam int SLOT_W_DEF = 8;

    typedef enum logic {
        ST_HUNT    = 1'b0,
        ST_RECEIVE = 1'b1
    } tdm_state_e;

endpackage

// File: rtl/tdm_slot_counter.sv
// Bit/slot position counter for a TDM frame. It steps once per accepted
// bit and wraps at the end of the frame. It can also be cleared to the
// frame start, or restarted so that the current bit counts as bit 0 of
// a new frame.
module tdm_slot_counter
    import tdm_demux_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int SLOT_W = SLOT_W_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        advance_i,
    input  logic                        restart_i,
    input  logic                        clear_i,
    output logic [$clog2(SLOT_W)-1:0]   bit_cnt_o,
    output logic [$clog2(NUM_CH)-1:0]   slot_cnt_o,
    output logic                        slot_end_o,
    output logic                        end_of_frame_o,
    output logic                        start_of_frame_o
);

    localparam int BIT_W   = $clog2(SLOT_W);
    localparam int SLOT_CW = $clog2(NUM_CH);

    logic [BIT_W-1:0]   bit_cnt_q,  bit_cnt_d;
    logic [SLOT_CW-1:0] slot_cnt_q, slot_cnt_d;

    assign slot_end_o       = (bit_cnt_q == BIT_W'(SLOT_W - 1));
    assign end_of_frame_o   = slot_end_o && (slot_cnt_q == SLOT_CW'(NUM_CH - 1));
    assign start_of_frame_o = (bit_cnt_q == '0) && (slot_cnt_q == '0);
    assign bit_cnt_o        = bit_cnt_q;
    assign slot_cnt_o       = slot_cnt_q;

    // Next position: clear wins, then restart (bit 0 consumed now), then a normal step
    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        slot_cnt_d = slot_cnt_q;
        if (clear_i) begin
            bit_cnt_d  = '0;
            slot_cnt_d = '0;
        end else if (restart_i) begin
            bit_cnt_d  = BIT_W'(1);
            slot_cnt_d = '0;
        end else if (advance_i) begin
            if (slot_end_o) begin
                bit_cnt_d  = '0;
                slot_cnt_d = end_of_frame_o ? '0 : slot_cnt_q + SLOT_CW'(1);
            end else begin
                bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end
        end
    end

    // Position registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q  <= '0;
            slot_cnt_q <= '0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            slot_cnt_q <= slot_cnt_d;
        end
    end

endmodule

// File: rtl/tdm_demux.sv
// TDM receive end: aligns to frame sync, assembles each slot MSB first,
// and publishes a complete parallel frame with a one-cycle valid strobe.
// Framing errors drop the partial frame and leave ch_data untouched.
module tdm_demux
    import tdm_demux_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int SLOT_W = SLOT_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       serial_in,
    input  logic                       bit_valid,
    input  logic                       frame_sync,
    output logic [NUM_CH*SLOT_W-1:0]   ch_data,
    output logic                       frame_valid,
    output logic                       sync_err,
    output logic                       locked
);

    tdm_state_e                  state_q, state_d;
    logic [SLOT_W-1:0]           shift_q, shift_d;
    logic [NUM_CH*SLOT_W-1:0]    staging_q, staging_d;
    logic [NUM_CH*SLOT_W-1:0]    ch_data_q, ch_data_d;
    logic                        frame_valid_q, frame_valid_d;
    logic                        sync_err_q, sync_err_d;

    logic                        cnt_advance, cnt_restart, cnt_clear;
    logic [$clog2(SLOT_W)-1:0]   bit_cnt;
    logic [$clog2(NUM_CH)-1:0]   slot_cnt;
    logic                        slot_end, end_of_frame, start_of_frame;
    logic [SLOT_W-1:0]           slot_word;

    tdm_slot_counter #(
        .NUM_CH (NUM_CH),
        .SLOT_W (SLOT_W)
    ) u_slot_counter (
        .clk              (clk),
        .rst_n            (rst_n),
        .advance_i        (cnt_advance),
        .restart_i        (cnt_restart),
        .clear_i          (cnt_clear),
        .bit_cnt_o        (bit_cnt),
        .slot_cnt_o       (slot_cnt),
        .slot_end_o       (slot_end),
        .end_of_frame_o   (end_of_frame),
        .start_of_frame_o (start_of_frame)
    );

    // The slot value as it will look once the current bit is shifted in
    assign slot_word = {shift_q[SLOT_W-2:0], serial_in};

    assign ch_data     = ch_data_q;
    assign frame_valid = frame_valid_q;
    assign sync_err    = sync_err_q;
    assign locked      = (state_q == ST_RECEIVE);

    // Framing FSM: sync checks at expected frame start, slot assembly and frame publish
    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        staging_d     = staging_q;
        ch_data_d     = ch_data_q;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;
        cnt_advance   = 1'b0;
        cnt_restart   = 1'b0;
        cnt_clear     = 1'b0;

        case (state_q)
            ST_HUNT: begin
                if (bit_valid && frame_sync) begin
                    cnt_restart = 1'b1;
                    shift_d     = slot_word;
                    state_d     = ST_RECEIVE;
                end
            end
            ST_RECEIVE: begin
                if (bit_valid) begin
                    if (start_of_frame && !frame_sync) begin
                        sync_err_d = 1'b1;
                        cnt_clear  = 1'b1;
                        state_d    = ST_HUNT;
                    end else if (!start_of_frame && frame_sync) begin
                        sync_err_d  = 1'b1;
                        cnt_restart = 1'b1;
                        shift_d     = slot_word;
                    end else begin
                        cnt_advance = 1'b1;
                        shift_d     = slot_word;
                        if (slot_end) begin
                            staging_d[int'(slot_cnt)*SLOT_W +: SLOT_W] = slot_word;
                            if (end_of_frame) begin
                                ch_data_d     = staging_d;
                                frame_valid_d = 1'b1;
                            end
                        end
                    end
                end
            end
            default: state_d = ST_HUNT;
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_HUNT;
            shift_q       <= '0;
            staging_q     <= '0;
            ch_data_q     <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            staging_q     <= staging_d;
            ch_data_q     <= ch_data_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
        end
    end

endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux with NUM_CH=4, SLOT_W=8. Expected
// frames are queued as they are transmitted and compared on frame_valid.
module tb_tdm_demux;

    localparam int NUM_CH = 4;
    localparam int SLOT_W = 8;
    localparam int FW     = NUM_CH * SLOT_W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          serial_in;
    logic          bit_valid;
    logic          frame_sync;
    logic [FW-1:0] ch_data;
    logic          frame_valid;
    logic          sync_err;
    logic          locked;

    int            checks  = 0;
    int            errors  = 0;
    int            fvCount = 0;
    int            seCount = 0;
    logic [FW-1:0] expQ[$];

    tdm_demux #(
        .NUM_CH (NUM_CH),
        .SLOT_W (SLOT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .serial_in   (serial_in),
        .bit_valid   (bit_valid),
        .frame_sync  (frame_sync),
        .ch_data     (ch_data),
        .frame_valid (frame_valid),
        .sync_err    (sync_err),
        .locked      (locked)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [FW-1:0] actual,
                               input logic [FW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of link inputs, changing them on the falling edge
    task automatic applyStimulus(input logic b, input logic s, input logic v);
        @(negedge clk);
        serial_in  = b;
        frame_sync = s;
        bit_valid  = v;
    endtask

    // Transmit the first nBits of a frame MSB-first per slot, slot 0 first
    task automatic sendFrame(input logic [FW-1:0] data, input logic withSync,
                             input logic gaps, input logic expectOut, input int nBits);
        logic b;
        for (int i = 0; i < nBits; i++) begin
            b = data[(i / SLOT_W) * SLOT_W + (SLOT_W - 1 - (i % SLOT_W))];
            if (expectOut && i == nBits - 1)
                expQ.push_back(data);
            applyStimulus(b, withSync && (i == 0), 1'b1);
            if (gaps)
                applyStimulus(1'b0, 1'b0, 1'b0);
        end
    endtask

    // Output monitor: scoreboard pops on each frame strobe, pulses are counted
    always @(negedge clk) begin
        if (frame_valid === 1'b1) begin
            fvCount++;
            checkOutput("fv_without_se", {{(FW-1){1'b0}}, sync_err}, '0);
            if (expQ.size() == 0)
                checkOutput("unexpected_frame", {{(FW-1){1'b0}}, frame_valid}, '0);
            else
                checkOutput("frame_data", ch_data, expQ.pop_front());
        end
        if (sync_err === 1'b1)
            seCount++;
    end

    initial begin
        rst_n      = 1'b0;
        serial_in  = 1'b0;
        bit_valid  = 1'b0;
        frame_sync = 1'b0;
        #12;
        checkOutput("rst_ch_data", ch_data, '0);
        checkOutput("rst_frame_valid", FW'(frame_valid), '0);
        checkOutput("rst_sync_err", FW'(sync_err), '0);
        checkOutput("rst_locked", FW'(locked), '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Clean frame, latency and single-cycle strobe
        sendFrame(32'h00FF3CA5, 1'b1, 1'b0, 1'b1, FW);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("t1_fv_latency", FW'(frame_valid), 1);
        checkOutput("t1_ch_data", ch_data, 32'h00FF3CA5);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("t1_fv_one_cycle", FW'(frame_valid), 0);
        checkOutput("t1_locked", FW'(locked), 1);
        checkOutput("t1_se_count", FW'(seCount), 0);
        checkOutput("t1_fv_count", FW'(fvCount), 1);

        // Two back-to-back frames with gaps between every bit
        sendFrame(32'h00FF3CA5, 1'b1, 1'b1, 1'b1, FW);
        sendFrame(32'h04030201, 1'b1, 1'b1, 1'b1, FW);
        repeat (3) applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("t2_ch_data", ch_data, 32'h04030201);
        checkOutput("t2_fv_count", FW'(fvCount), 3);
        checkOutput("t2_locked", FW'(locked), 1);
        checkOutput("t2_se_count", FW'(seCount), 0);

        // Missing sync at expected frame start, then relock
        sendFrame(32'h00FF3CA5, 1'b1, 1'b0, 1'b1, FW);
        sendFrame(32'h12345678, 1'b0, 1'b0, 1'b0, FW);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("t3_se_count", FW'(seCount), 1);
        checkOutput("t3_unlocked", FW'(locked), 0);
        checkOutput("t3_ch_hold", ch_data, 32'h00FF3CA5);
        sendFrame(32'hCAFEF00D, 1'b1, 1'b0, 1'b1, FW);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("t3_relocked", FW'(locked), 1);
        checkOutput("t3_ch_data", ch_data, 32'hCAFEF00D);
        checkOutput("t3_fv_count", FW'(fvCount), 5);

        // Early sync at bit 13 restarts the frame
        sendFrame(32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 13);
        sendFrame(32'h44332211, 1'b1, 1'b0, 1'b1, FW);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("t4_se_count", FW'(seCount), 2);
        checkOutput("t4_fv_count", FW'(fvCount), 6);
        checkOutput("t4_ch_data", ch_data, 32'h44332211);
        checkOutput("t4_locked", FW'(locked), 1);

        // Asynchronous reset in the middle of a frame
        sendFrame(32'hA1B2C3D4, 1'b1, 1'b0, 1'b0, 20);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t5_ch_data", ch_data, '0);
        checkOutput("t5_locked", FW'(locked), 0);
        checkOutput("t5_frame_valid", FW'(frame_valid), 0);
        checkOutput("t5_sync_err", FW'(sync_err), 0);
        bit_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Ones without sync while hunting are ignored
        for (int i = 0; i < 16; i++)
            applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("t6_ch_data", ch_data, '0);
        checkOutput("t6_locked", FW'(locked), 0);
        checkOutput("t6_fv_count", FW'(fvCount), 6);
        checkOutput("t6_se_count", FW'(seCount), 2);

        // First valid frame after the reset
        sendFrame(32'h5A5AC3C3, 1'b1, 1'b1, 1'b1, FW);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("t5_after_ch_data", ch_data, 32'h5A5AC3C3);
        checkOutput("t5_after_locked", FW'(locked), 1);
        checkOutput("t5_after_fv_count", FW'(fvCount), 7);
        checkOutput("queue_empty", FW'(expQ.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
